// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: groups the handshake, ALU result inputs, bus read
// enables and register outputs of alu_result_stage.
//   master : control unit / ALU side (drives start, alu_sel, c_hi/c_lo, enables)
//   slave  : alu_result_stage (drives busy, done, Z/HI/LO, bus_data, flags)
interface alu_result_stage_if;
    logic        start;
    logic [3:0]  alu_sel;
    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic        zlo_out;
    logic        zhi_out;
    logic        hi_out;
    logic        lo_out;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] bus_data;
    logic [1:0]  status_flags;

    modport master (
        output start, alu_sel, c_hi, c_lo, zlo_out, zhi_out, hi_out, lo_out,
        input  busy, done, z_hi, z_lo, hi_reg, lo_reg, bus_data, status_flags
    );

    modport slave (
        input  start, alu_sel, c_hi, c_lo, zlo_out, zhi_out, hi_out, lo_out,
        output busy, done, z_hi, z_lo, hi_reg, lo_reg, bus_data, status_flags
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: retires one ALU operation at a time. On start (in IDLE)
// the op code is latched and a per-op settle window counted down; at the end
// of the window c_hi/c_lo are captured into Z (and HI/LO for mul/div), then
// done pulses for one cycle.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-high reset
//   io   - alu_result_stage_if.slave: start/alu_sel/c_hi/c_lo/read enables in,
//          busy/done/z_hi/z_lo/hi_reg/lo_reg/bus_data/status_flags out
// Optional feature: define ALU_STATUS_FLAGS_EN to enable the {negative, zero}
// status flags; otherwise status_flags is tied to 2'b00.
module alu_result_stage #(
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 8,
    parameter int BASIC_CYCLES = 1
) (
    input logic              clk,
    input logic              clr,
    alu_result_stage_if.slave io
);

    localparam int MUL_N   = (MUL_CYCLES   < 1) ? 1 : MUL_CYCLES;
    localparam int DIV_N   = (DIV_CYCLES   < 1) ? 1 : DIV_CYCLES;
    localparam int BASIC_N = (BASIC_CYCLES < 1) ? 1 : BASIC_CYCLES;
    localparam int MAX_MD  = (MUL_N > DIV_N) ? MUL_N : DIV_N;
    localparam int MAX_N   = (MAX_MD > BASIC_N) ? MAX_MD : BASIC_N;
    // Counter holds N-1, so clog2(MAX_N) bits suffice.
    localparam int CNT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       z_hi_q, z_hi_d;
    logic [31:0]       z_lo_q, z_lo_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              capture;

    function automatic logic [CNT_W-1:0] load_for(input logic [3:0] sel);
        case (sel)
            OP_MUL:  load_for = CNT_W'(MUL_N - 1);
            OP_DIV:  load_for = CNT_W'(DIV_N - 1);
            default: load_for = CNT_W'(BASIC_N - 1);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    op_d    = io.alu_sel;
                    cnt_d   = load_for(io.alu_sel);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            if (op_q < 4'd3) begin
                z_hi_d = '0;
                z_lo_d = '0;
            end else begin
                z_hi_d = io.c_hi;
                z_lo_d = io.c_lo;
            end
            if (op_q == OP_MUL || op_q == OP_DIV) begin
                hi_d = io.c_hi;
                lo_d = io.c_lo;
            end
        end

        // busy/done are registered: derive them from the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef ALU_STATUS_FLAGS_EN
    logic [1:0] flags_q, flags_d;

    // Reserved ops retire a forced zero, so their flags describe that zero.
    always_comb begin
        flags_d = flags_q;
        if (capture) begin
            if (op_q < 4'd3) begin
                flags_d = 2'b01;
            end else if (op_q == OP_MUL || op_q == OP_DIV) begin
                flags_d = {io.c_hi[31], ({io.c_hi, io.c_lo} == 64'd0)};
            end else begin
                flags_d = {io.c_lo[31], (io.c_lo == 32'd0)};
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) flags_q <= '0;
        else     flags_q <= flags_d;
    end

    assign io.status_flags = flags_q;
`else
    assign io.status_flags = '0;
`endif

    assign io.busy   = busy_q;
    assign io.done   = done_q;
    assign io.z_hi   = z_hi_q;
    assign io.z_lo   = z_lo_q;
    assign io.hi_reg = hi_q;
    assign io.lo_reg = lo_q;

    always_comb begin
        if (io.zlo_out)     io.bus_data = z_lo_q;
        else if (io.zhi_out) io.bus_data = z_hi_q;
        else if (io.hi_out)  io.bus_data = hi_q;
        else if (io.lo_out)  io.bus_data = lo_q;
        else                 io.bus_data = '0;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int MUL_C = 4;
    localparam int DIV_C = 8;
    localparam int BAS_C = 1;

    logic clk = 1'b0;
    logic clr = 1'b1;

    alu_result_stage_if io();

    alu_result_stage #(
        .MUL_CYCLES(MUL_C),
        .DIV_CYCLES(DIV_C),
        .BASIC_CYCLES(BAS_C)
    ) dut (
        .clk(clk),
        .clr(clr),
        .io(io)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the op as a timeline: capture at start edge + N, done during
    // the following cycle, idle again one edge later.
    bit          m_active = 0;
    int          m_op = 0;
    int          m_cyc = 0;
    int          m_cap = 0;
    int          m_end = 0;
    logic [31:0] m_zhi = '0, m_zlo = '0, m_hi = '0, m_lo = '0;
    logic [1:0]  m_flags = '0;

    function automatic int n_for(input int sel);
        if (sel == 5) return MUL_C;
        if (sel == 6) return DIV_C;
        return BAS_C;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_active = 0;
            m_zhi = '0; m_zlo = '0; m_hi = '0; m_lo = '0; m_flags = '0;
        end else begin
            m_cyc++;
            if (m_active) begin
                if (m_cyc == m_cap) begin
                    if (m_op <= 2) begin
                        m_zhi = '0; m_zlo = '0;
                    end else begin
                        m_zhi = io.c_hi; m_zlo = io.c_lo;
                    end
                    if (m_op == 5 || m_op == 6) begin
                        m_hi = io.c_hi; m_lo = io.c_lo;
                    end
`ifdef ALU_STATUS_FLAGS_EN
                    if (m_op <= 2)
                        m_flags = 2'b01;
                    else if (m_op == 5 || m_op == 6)
                        m_flags = {io.c_hi[31], ({io.c_hi, io.c_lo} == 64'd0)};
                    else
                        m_flags = {io.c_lo[31], (io.c_lo == 32'd0)};
`endif
                end
                if (m_cyc == m_end) m_active = 0;
            end else if (io.start) begin
                m_active = 1;
                m_op     = int'(io.alu_sel);
                m_cap    = m_cyc + n_for(int'(io.alu_sel));
                m_end    = m_cap + 1;
            end
        end
    end

    function automatic logic [31:0] m_bus();
        if (io.zlo_out) return m_zlo;
        if (io.zhi_out) return m_zhi;
        if (io.hi_out)  return m_hi;
        if (io.lo_out)  return m_lo;
        return 32'd0;
    endfunction

    // ---------------- compare process ----------------
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(posedge clk) begin
        #1;
        chk("busy",   io.busy,   m_active);
        chk("done",   io.done,   m_active && (m_cyc == m_cap));
        chk("z_hi",   io.z_hi,   m_zhi);
        chk("z_lo",   io.z_lo,   m_zlo);
        chk("hi_reg", io.hi_reg, m_hi);
        chk("lo_reg", io.lo_reg, m_lo);
        chk("bus",    io.bus_data, m_bus());
        chk("flags",  io.status_flags, m_flags);
        if (io.done) done_cnt++;
        if (io.busy) busy_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [3:0] sel, input logic [31:0] hi,
                          input logic [31:0] lo, output int lat);
        @(negedge clk);
        io.alu_sel = sel; io.c_hi = hi; io.c_lo = lo; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        lat = 0;
        while (!io.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    initial begin
        int lat, d0, b0;
        io.start = 0; io.alu_sel = '0; io.c_hi = '0; io.c_lo = '0;
        io.zlo_out = 0; io.zhi_out = 0; io.hi_out = 0; io.lo_out = 0;

        repeat (2) @(negedge clk);
        chk("rst_busy", io.busy, 1'b0);
        chk("rst_done", io.done, 1'b0);
        chk("rst_zlo",  io.z_lo, 32'd0);
        chk("rst_flags", io.status_flags, 2'b00);
        clr = 1'b0;

        // Add
        run_op(4'd3, 32'h1, 32'h5, lat);
        chk("add_lat", lat, 1);
        chk("add_zlo", io.z_lo, 32'h5);
        chk("add_zhi", io.z_hi, 32'h1);
        chk("add_hi",  io.hi_reg, 32'h0);
        chk("add_lo",  io.lo_reg, 32'h0);
        io.zlo_out = 1; #1;
        chk("add_bus", io.bus_data, 32'h5);
        io.zlo_out = 0;

        // Mul
        b0 = busy_cnt;
        run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, lat);
        chk("mul_lat",  lat, 4);
        chk("mul_busy", busy_cnt - b0, 5);
        chk("mul_hi",   io.hi_reg, 32'hFFFF_FFFF);
        chk("mul_lo",   io.lo_reg, 32'hFFFF_FFFA);
`ifdef ALU_STATUS_FLAGS_EN
        chk("mul_flags", io.status_flags, 2'b10);
`endif

        // Div: operand changes mid-window, stray start during WAIT
        d0 = done_cnt;
        @(negedge clk);
        io.alu_sel = 4'd6; io.c_hi = 32'h0; io.c_lo = 32'h1; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        lat = 0;
        while (!io.done && lat < 40) begin
            if (lat == 2) begin io.start = 1'b1; io.alu_sel = 4'd3; end
            if (lat == 3) io.start = 1'b0;
            if (lat == 4) io.c_lo = 32'h3;
            @(negedge clk);
            lat++;
        end
        repeat (6) @(negedge clk);
        chk("div_lat",   lat, 8);
        chk("div_zlo",   io.z_lo, 32'h3);
        chk("div_lo",    io.lo_reg, 32'h3);
        chk("div_hi",    io.hi_reg, 32'h0);
        chk("div_dones", done_cnt - d0, 1);

        // Reserved
        run_op(4'd1, 32'h1234, 32'hDEAD, lat);
        chk("rsv_lat", lat, 1);
        chk("rsv_zlo", io.z_lo, 32'h0);
        chk("rsv_zhi", io.z_hi, 32'h0);
`ifdef ALU_STATUS_FLAGS_EN
        chk("rsv_flags", io.status_flags, 2'b01);
`endif

        // Bus priority
        run_op(4'd5, 32'h22, 32'h5, lat);
        run_op(4'd3, 32'h0, 32'h11, lat);
        io.zlo_out = 1; io.hi_out = 1; #1;
        chk("bus_zlo_hi", io.bus_data, 32'h11);
        io.zlo_out = 0; #1;
        chk("bus_hi", io.bus_data, 32'h22);
        io.hi_out = 0; #1;
        chk("bus_none", io.bus_data, 32'h0);
        io.lo_out = 1; #1;
        chk("bus_lo", io.bus_data, 32'h5);
        io.zhi_out = 1; #1;
        chk("bus_zhi_lo", io.bus_data, 32'h0);
        io.zhi_out = 0; io.lo_out = 0;

        // Reset mid-op
        d0 = done_cnt;
        @(negedge clk);
        io.alu_sel = 4'd6; io.c_hi = 32'h7; io.c_lo = 32'h9; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (2) @(negedge clk);
        #3 clr = 1'b1;
        #1;
        chk("clr_busy", io.busy, 1'b0);
        chk("clr_done", io.done, 1'b0);
        chk("clr_zlo",  io.z_lo, 32'h0);
        chk("clr_zhi",  io.z_hi, 32'h0);
        chk("clr_hi",   io.hi_reg, 32'h0);
        chk("clr_lo",   io.lo_reg, 32'h0);
        chk("clr_flags", io.status_flags, 2'b00);
        @(negedge clk);
        clr = 1'b0;
        repeat (15) @(negedge clk);
        chk("clr_no_done", done_cnt - d0, 0);
        chk("clr_idle", io.busy, 1'b0);

        // Back-to-back after reset recovery
        run_op(4'd7, 32'hA, 32'hB, lat);
        chk("and_lat", lat, 1);
        run_op(4'd15, 32'h8000_0000, 32'h0, lat);
        chk("not_zlo", io.z_lo, 32'h0);
        chk("not_zhi", io.z_hi, 32'h8000_0000);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream of the 32-bit ALU; consumes its c_hi/c_lo outputs and retires each operation.
- Holds the operation for a per-op multicycle settle window, then captures into the 64-bit Z register. Mul/div results are also written to the HI/LO registers.
- Drives the selected register onto the CPU bus with a start/busy/done handshake toward the control unit.

Parameters:
- MUL_CYCLES, 4, settle cycles for alu_sel=5 (booth multiply); values <1 treated as 1.
- DIV_CYCLES, 8, settle cycles for alu_sel=6 (non-restoring divide); values <1 treated as 1.
- BASIC_CYCLES, 1, settle cycles for all other alu_sel values; values <1 treated as 1.

Ports:
- clk  in  1  single system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request to retire the ALU op; sampled only in IDLE.
- alu_sel  in  4  ALU op code: 3 add, 4 sub, 5 mul, 6 div, 7 and, 8 or, 9 shr, 10 shra, 11 shl, 12 ror, 13 rol, 14 neg, 15 not, 0-2 reserved.
- c_hi  in  32  ALU high result.
- c_lo  in  32  ALU low result.
- zlo_out, zhi_out, hi_out, lo_out  in  1 each  bus read enables.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- z_hi, z_lo  out  32 each  Z register.
- hi_reg, lo_reg  out  32 each  HI/LO registers.
- bus_data  out  32  bus drive value.
- status_flags  out  2  {negative, zero}; see Optional Feature.

Behaviour:
- Reset (clr high, async): state IDLE; busy=0, done=0; z_hi, z_lo, hi_reg, lo_reg, status_flags all 0. An operation in progress is abandoned with no capture.
- FSM states:
  - IDLE: on start=1 at edge E0, latch alu_sel into op_q; load cnt = N-1, where N is the op's cycle count; go to WAIT.
  - WAIT: busy=1. If cnt!=0, decrement. If cnt==0, capture at this edge and go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then IDLE.
- Timing: capture occurs at edge E0+N. done is high during the cycle after capture; busy is high from E0 through the done cycle.
- start is ignored in WAIT and DONE; there is no queueing. Back-to-back ops: the earliest next start is sampled in the first IDLE cycle after done.
- alu_sel changes after E0 have no effect. c_hi/c_lo are sampled only at the capture edge, so the ALU operands must be held stable until then.
- Capture:
  - z_lo<=c_lo and z_hi<=c_hi for ops 3-15.
  - For op_q 0-2, z_hi/z_lo <= 0 regardless of inputs.
  - For op_q 5 or 6, additionally hi_reg<=c_hi and lo_reg<=c_lo. All other ops leave HI/LO unchanged.
- Bus: combinational from registers, priority zlo_out > zhi_out > hi_out > lo_out. All enables low -> bus_data=0. Reads are valid in any state and return the current register values.

Optional Feature:
- Macro ALU_STATUS_FLAGS_EN.
- Defined: at each capture, status_flags[0] <= (value==0) and status_flags[1] <= value[31].
  - value = {c_hi,c_lo} (64-bit zero test, sign from c_hi[31]) for mul/div.
  - value = c_lo for all other ops.
  - Flags hold until the next capture; cleared by clr.
- Undefined: status_flags tied to 2'b00 and no flag logic is present.

Test Plan:
- Add: alu_sel=3, c_lo=0x00000005, c_hi=0x00000001, start pulse -> done exactly 1 cycle after start (BASIC_CYCLES=1); z_lo=0x5, z_hi=0x1; hi_reg/lo_reg stay 0; zlo_out=1 gives bus_data=0x5.
- Mul: alu_sel=5, c_hi=0xFFFFFFFF, c_lo=0xFFFFFFFA -> busy high for 5 cycles; done 4 cycles after start; hi_reg=0xFFFFFFFF, lo_reg=0xFFFFFFFA; with macro, flags=2'b10.
- Div: alu_sel=6, start; c_lo changed from 0x1 to 0x3 at cycle 5 -> capture at start+8 takes 0x3; done at start+8. A second start during WAIT is ignored (exactly one done pulse).
- Reserved: alu_sel=1 with c_lo=0xDEAD -> z_lo=0, z_hi=0; with macro, flags=2'b01.
- Reset mid-op: start div, assert clr at cycle 3 -> busy/done drop immediately; all registers 0; no done pulse after clr releases.
- Bus priority: z_lo=0x11, hi_reg=0x22, zlo_out=hi_out=1 -> bus_data=0x11; hi_out alone -> 0x22; no enables -> 0.
